// File: rtl/wb_write_queue_pkg.sv
// Shared register-bank constants and helpers for the write-back queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// The register bank and the write queue both take their address and data
// widths from here, so the two sides always agree on the register-file shape.
package wb_write_queue_pkg;

    localparam int NREG     = 32;             // registers in the bank
    localparam int BR_AW    = $clog2(NREG);   // register address width
    localparam int BR_DW    = 32;             // register data width
    localparam int REG_ZERO = 0;              // hard-wired zero register; writes to it are dropped

    localparam int WQ_DEPTH = 4;              // default queue depth

    // Pointer increment with natural wrap; DEPTH is a power of two so the
    // carry out of the top bit is simply discarded.
    function automatic logic [$clog2(WQ_DEPTH)-1:0] wq_ptr_inc(
        input logic [$clog2(WQ_DEPTH)-1:0] ptr
    );
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/wb_write_queue_if.sv
// Write-back request, bank write port and forwarding lookup bundle.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the request side; wr_hold stalls the drain.
//
// master : the surrounding pipeline (drives requests, hold and lookup address)
// slave  : the write queue (drives ready, bank write port, hit and occupancy)
interface wb_write_queue_if
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH,
    parameter int AW    = BR_AW,
    parameter int DW    = BR_DW
);
    logic                     in_valid;
    logic                     in_ready;
    logic [AW-1:0]            in_wa;
    logic [DW-1:0]            in_data;
    logic                     wr_hold;
    logic [AW-1:0]            wa;
    logic [DW-1:0]            data_in;
    logic                     we;
    logic [AW-1:0]            q_addr;
    logic                     hit;
    logic [DW-1:0]            hit_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_wa, in_data, wr_hold, q_addr,
        input  in_ready, wa, data_in, we, hit, hit_data, count
    );

    modport slave (
        input  in_valid, in_wa, in_data, wr_hold, q_addr,
        output in_ready, wa, data_in, we, hit, hit_data, count
    );
endinterface

// File: rtl/wb_fwd_match.sv
// Forwarding search: youngest occupied queue entry whose address equals q_addr.
// Latency: purely combinational.
// Backpressure: none; pure lookup on registered queue state.
//
// Ports: ent_addr/ent_data = storage array, rd_ptr/count = occupied window,
//        q_addr = lookup address, hit/hit_data = match flag and youngest data.
module wb_fwd_match #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic [AW-1:0]            ent_addr [DEPTH],
    input  logic [DW-1:0]            ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            q_addr,
    output logic                     hit,
    output logic [DW-1:0]            hit_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk from oldest (rd_ptr) to youngest; a later match overwrites an
    // earlier one, so the last one standing is the youngest.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        if (q_addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (ent_addr[idx] == q_addr)) begin
                    hit      = 1'b1;
                    hit_data = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Write-back queue: buffers (rd, data) requests and drains one per cycle into the bank write port.
// Latency: accepted at edge N -> we during cycle N+1 -> committed at edge N+1 (1 cycle minimum).
// Backpressure: in_ready = not full (no pass-through when full); wr_hold stalls the drain.
//
// Ports: clk/rst_n plain; bus (slave modport) carries the request handshake,
//        wr_hold, bank write port (wa/data_in/we), forwarding lookup and count.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH,
    parameter int AW    = BR_AW,
    parameter int DW    = BR_DW
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_write_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] ent_addr [DEPTH];
    logic [DW-1:0] ent_data [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic ready;
    logic push;
    logic occupied;
    logic pop;

    assign ready    = (count != CW'(DEPTH));
    assign occupied = (count != '0);
    assign pop      = occupied && !bus.wr_hold;

    // A write to the zero register is acknowledged but never stored.
    assign push     = bus.in_valid && ready && (bus.in_wa != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: every read of it is qualified by count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= bus.in_wa;
            ent_data[wr_ptr] <= bus.in_data;
        end
    end

    assign bus.in_ready = ready;
    assign bus.we       = pop;
    assign bus.wa       = occupied ? ent_addr[rd_ptr] : '0;
    assign bus.data_in  = occupied ? ent_data[rd_ptr] : '0;
    assign bus.count    = count;

    wb_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd (
        .ent_addr (ent_addr),
        .ent_data (ent_data),
        .rd_ptr   (rd_ptr),
        .count    (count),
        .q_addr   (bus.q_addr),
        .hit      (bus.hit),
        .hit_data (bus.hit_data)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: reset, drain, hold/full, forwarding, zero register,
// streaming across pointer wrap, asynchronous reset with pending entries.
// Bank writes are logged on the falling edge and compared against hand-written orders.
module tb_wb_write_queue;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    logic [4:0]  log_wa  [$];
    logic [31:0] log_dat [$];

    wb_write_queue_if #(.DEPTH(4), .AW(5), .DW(32)) bus ();

    wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record what the bank would commit at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && bus.we) begin
            log_wa.push_back(bus.wa);
            log_dat.push_back(bus.data_in);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_wa    = '0;
        bus.in_data  = '0;
        bus.wr_hold  = 1'b0;
        bus.q_addr   = '0;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_we",       bus.we,       0);
        chk("rst_wa",       bus.wa,       0);
        chk("rst_data_in",  bus.data_in,  0);
        chk("rst_hit",      bus.hit,      0);
        chk("rst_hit_data", bus.hit_data, 0);
        chk("rst_count",    bus.count,    0);
        rst_n = 1'b1;

        // ---------------- single write, one-cycle latency
        bus.in_valid = 1'b1;
        bus.in_wa    = 5'd3;
        bus.in_data  = 32'hDEADBEEF;
        #1;
        chk("t1_ready_pre", bus.in_ready, 1);
        chk("t1_we_pre",    bus.we,       0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t1_we",      bus.we,       1);
        chk("t1_wa",      bus.wa,       3);
        chk("t1_data_in", bus.data_in,  32'hDEADBEEF);
        chk("t1_count1",  bus.count,    1);
        chk("t1_ready",   bus.in_ready, 1);
        tick();
        chk("t1_count0",  bus.count,    0);
        chk("t1_we_off",  bus.we,       0);
        chk("t1_nwr",     log_wa.size(), 1);
        chk("t1_log_wa",  log_wa[0],    3);
        chk("t1_log_dat", log_dat[0],   32'hDEADBEEF);
        log_wa.delete();
        log_dat.delete();

        // ---------------- hold, fill to full, reject 5th, drain in order
        bus.wr_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_wa    = 5'(i);
            bus.in_data  = 32'h100 + 32'(i);
            tick();
            #1;
            chk("t2_fill_count", bus.count, 64'(i));
        end
        bus.in_wa   = 5'd5;
        bus.in_data = 32'h105;
        #1;
        chk("t2_full_ready", bus.in_ready, 0);
        chk("t2_held_we",    bus.we,       0);
        chk("t2_head_wa",    bus.wa,       1);
        chk("t2_head_data",  bus.data_in,  32'h101);
        tick();
        bus.q_addr = 5'd5;
        #1;
        chk("t2_5th_count",  bus.count, 4);
        chk("t2_5th_hit",    bus.hit,   0);
        bus.in_valid = 1'b0;
        bus.q_addr   = '0;
        bus.wr_hold  = 1'b0;
        #1;
        chk("t2_release_we", bus.we, 1);
        repeat (4) tick();
        chk("t2_drained", bus.count, 0);
        chk("t2_nwr", log_wa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_log_wa",  log_wa[i],  64'(i + 1));
            chk("t2_log_dat", log_dat[i], 64'(32'h101 + 32'(i)));
        end
        log_wa.delete();
        log_dat.delete();

        // ---------------- forwarding: youngest match wins, across pointer wrap
        bus.wr_hold  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_wa = 5'd7; bus.in_data = 32'h11; tick();
        bus.in_wa = 5'd9; bus.in_data = 32'h33; tick();
        bus.in_wa = 5'd7; bus.in_data = 32'h22; tick();
        bus.in_valid = 1'b0;
        bus.q_addr   = 5'd7;
        #1;
        chk("t3_hit7",      bus.hit,      1);
        chk("t3_hit7_data", bus.hit_data, 32'h22);
        bus.q_addr = 5'd9;
        #1;
        chk("t3_hit9_data", bus.hit_data, 32'h33);
        bus.q_addr = 5'd12;
        #1;
        chk("t3_miss_hit",  bus.hit,      0);
        chk("t3_miss_data", bus.hit_data, 0);
        bus.q_addr = 5'd0;
        #1;
        chk("t3_zero_hit",  bus.hit,      0);
        chk("t3_zero_data", bus.hit_data, 0);
        // A request still on the input does not forward.
        bus.q_addr   = 5'd7;
        bus.in_valid = 1'b1;
        bus.in_wa    = 5'd7;
        bus.in_data  = 32'h44;
        #1;
        chk("t3_inflight_data", bus.hit_data, 32'h22);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t3_wrap_data", bus.hit_data, 32'h44);
        bus.wr_hold = 1'b0;
        repeat (3) tick();
        chk("t3_last_count", bus.count,    1);
        chk("t3_last_we",    bus.we,       1);
        chk("t3_pop_hit",    bus.hit,      1);
        chk("t3_pop_data",   bus.hit_data, 32'h44);
        tick();
        chk("t3_empty_hit",  bus.hit,      0);
        chk("t3_nwr", log_wa.size(), 4);
        chk("t3_log0", {log_wa[0], log_dat[0]}, {5'd7, 32'h11});
        chk("t3_log1", {log_wa[1], log_dat[1]}, {5'd9, 32'h33});
        chk("t3_log2", {log_wa[2], log_dat[2]}, {5'd7, 32'h22});
        chk("t3_log3", {log_wa[3], log_dat[3]}, {5'd7, 32'h44});
        log_wa.delete();
        log_dat.delete();
        bus.q_addr = '0;

        // ---------------- zero-register write is accepted and dropped
        bus.in_valid = 1'b1;
        bus.in_wa    = 5'd0;
        bus.in_data  = 32'h55;
        #1;
        chk("t4_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t4_count", bus.count, 0);
        chk("t4_we",    bus.we,    0);
        tick();
        chk("t4_nwr", log_wa.size(), 0);

        // ---------------- streaming push+pop every cycle, several wraps
        for (int i = 0; i <= 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_wa    = 5'(10 + i);
            bus.in_data  = 32'hA000 + 32'(i);
            tick();
            #1;
            chk("t5_count", bus.count, 1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("t5_drained", bus.count, 0);
        chk("t5_nwr", log_wa.size(), 11);
        for (int i = 0; i <= 10; i++) begin
            chk("t5_log", {log_wa[i], log_dat[i]}, {5'(10 + i), 32'hA000 + 32'(i)});
        end
        log_wa.delete();
        log_dat.delete();

        // ---------------- async reset with pending entries
        bus.wr_hold  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_wa = 5'd5; bus.in_data = 32'h501; tick();
        bus.in_wa = 5'd6; bus.in_data = 32'h601; tick();
        bus.in_wa = 5'd7; bus.in_data = 32'h701; tick();
        bus.in_valid = 1'b0;
        bus.q_addr   = 5'd5;
        #1;
        chk("t6_pre_count", bus.count, 3);
        chk("t6_pre_hit",   bus.hit,   1);
        rst_n       = 1'b0;
        bus.wr_hold = 1'b0;
        #1;
        chk("t6_rst_we",    bus.we,    0);
        chk("t6_rst_count", bus.count, 0);
        chk("t6_rst_hit",   bus.hit,   0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_post_we",    bus.we,    0);
        chk("t6_post_count", bus.count, 0);
        chk("t6_nwr", log_wa.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
